// File: rtl/psram_qpi_master.sv
// psram_qpi_master: QPI PSRAM initiator.
// Turns single-beat bus requests into 38h quad-write / EBh quad-read frames.
// sck runs at clk/2. Each nibble is one low phase followed by one high phase.
// Optional macro PSRAM_QPI_ENTER_EN: the first frame after reset is preceded
// by an SPI-mode 35h (enter QPI) frame.
module psram_qpi_master #(
   parameter int RD_WAIT_CYCLES = 7,
   parameter int CE_GAP         = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [23:0] req_addr,
   input  logic [1:0]  req_len,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        sck,
   output logic        ce_n,
   output logic [3:0]  dio_o,
   output logic [3:0]  dio_oe,
   input  logic [3:0]  dio_i
);

   typedef enum logic [3:0] {
      S_IDLE,
`ifdef PSRAM_QPI_ENTER_EN
      S_QPI_ENTER,
      S_ENTER_GAP,
`endif
      S_CMD,
      S_ADDR,
      S_WDATA,
      S_RWAIT,
      S_RDATA,
      S_DONE
   } state_t;

`ifdef PSRAM_QPI_ENTER_EN
   localparam logic [7:0] ENTER_CMD = 8'h35;
   logic qpi_entered_q, qpi_entered_d;
`endif

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        sck_q, sck_d;
   logic        ce_n_q, ce_n_d;
   logic [3:0]  dio_o_q, dio_o_d;
   logic [3:0]  dio_oe_q, dio_oe_d;
   logic        ready_q, ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        we_q, we_d;
   logic [23:0] addr_q, addr_d;
   logic [1:0]  len_q, len_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_sh_q, rdata_sh_d;
   logic        start_frame, end_frame, start_we;
   logic [2:0]  nib_k;

   // Byte k/2 of a little-endian word, high nibble for even k.
   function automatic logic [3:0] data_nib(input logic [31:0] w, input logic [2:0] k);
      return w[{k[2:1], ~k[0], 2'b00} +: 4];
   endfunction

   // Address nibble k, most significant nibble first.
   function automatic logic [3:0] addr_nib(input logic [23:0] a, input logic [2:0] k);
      logic [23:0] s;
      s = a << {k, 2'b00};
      return s[23:20];
   endfunction

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch); blocking '=' is right here.
      state_d     = state_q;
      cnt_d       = cnt_q;
      sck_d       = sck_q;
      ce_n_d      = ce_n_q;
      dio_o_d     = dio_o_q;
      dio_oe_d    = dio_oe_q;
      ready_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      we_d        = we_q;
      addr_d      = addr_q;
      len_d       = len_q;
      wdata_d     = wdata_q;
      rdata_sh_d  = rdata_sh_q;
`ifdef PSRAM_QPI_ENTER_EN
      qpi_entered_d = qpi_entered_q;
`endif
      start_frame = 1'b0;
      end_frame   = 1'b0;
      start_we    = we_q;
      nib_k       = cnt_q[2:0] + 3'd1;

      unique case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (req_valid && ready_q) begin
               ready_d  = 1'b0;
               we_d     = req_we;
               addr_d   = req_addr;
               len_d    = req_len;
               wdata_d  = req_wdata;
               start_we = req_we;
`ifdef PSRAM_QPI_ENTER_EN
               if (!qpi_entered_q) begin
                  state_d  = S_QPI_ENTER;
                  cnt_d    = '0;
                  ce_n_d   = 1'b0;
                  sck_d    = 1'b0;
                  dio_oe_d = 4'b0001;
                  dio_o_d  = {3'b000, ENTER_CMD[7]};
               end else begin
                  start_frame = 1'b1;
               end
`else
               start_frame = 1'b1;
`endif
            end
         end
`ifdef PSRAM_QPI_ENTER_EN
         S_QPI_ENTER: begin
            if (!sck_q) sck_d = 1'b1;
            else if (cnt_q == 8'd7) begin
               state_d       = S_ENTER_GAP;
               cnt_d         = '0;
               sck_d         = 1'b0;
               ce_n_d        = 1'b1;
               dio_oe_d      = 4'h0;
               dio_o_d       = 4'h0;
               qpi_entered_d = 1'b1;
            end else begin
               sck_d   = 1'b0;
               cnt_d   = cnt_q + 8'd1;
               dio_o_d = {3'b000, ENTER_CMD[3'd6 - cnt_q[2:0]]};
            end
         end
         S_ENTER_GAP: begin
            if (int'(cnt_q) >= CE_GAP - 1) start_frame = 1'b1;
            else cnt_d = cnt_q + 8'd1;
         end
`endif
         S_CMD: begin
            if (!sck_q) sck_d = 1'b1;
            else begin
               sck_d = 1'b0;
               if (cnt_q == 8'd0) begin
                  cnt_d   = 8'd1;
                  dio_o_d = we_q ? 4'h8 : 4'hB;
               end else begin
                  state_d = S_ADDR;
                  cnt_d   = '0;
                  dio_o_d = addr_q[23:20];
               end
            end
         end
         S_ADDR: begin
            if (!sck_q) sck_d = 1'b1;
            else begin
               sck_d = 1'b0;
               cnt_d = '0;
               if (cnt_q != 8'd5) begin
                  cnt_d   = cnt_q + 8'd1;
                  dio_o_d = addr_nib(addr_q, nib_k);
               end else if (we_q) begin
                  state_d = S_WDATA;
                  dio_o_d = data_nib(wdata_q, 3'd0);
               end else begin
                  // Bus turnaround: release dio for the whole wait period.
                  state_d  = S_RWAIT;
                  dio_oe_d = 4'h0;
                  dio_o_d  = 4'h0;
               end
            end
         end
         S_WDATA: begin
            if (!sck_q) sck_d = 1'b1;
            else if (cnt_q == {5'd0, len_q, 1'b1}) end_frame = 1'b1;
            else begin
               sck_d   = 1'b0;
               cnt_d   = cnt_q + 8'd1;
               dio_o_d = data_nib(wdata_q, nib_k);
            end
         end
         S_RWAIT: begin
            if (!sck_q) sck_d = 1'b1;
            else begin
               sck_d = 1'b0;
               if (int'(cnt_q) == RD_WAIT_CYCLES - 1) begin
                  state_d = S_RDATA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         S_RDATA: begin
            // Capture on the edge that raises sck: the nibble the device drove after the previous rise.
            if (!sck_q) begin
               sck_d = 1'b1;
               rdata_sh_d[{cnt_q[2:1], ~cnt_q[0], 2'b00} +: 4] = dio_i;
            end else if (cnt_q == 8'd7) begin
               end_frame   = 1'b1;
               rsp_rdata_d = rdata_sh_q;
            end else begin
               sck_d = 1'b0;
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            // The accept cycle in IDLE is the last ce_n-high cycle of the gap.
            if (int'(cnt_q) >= CE_GAP - 2) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start_frame) begin
         state_d  = S_CMD;
         cnt_d    = '0;
         ce_n_d   = 1'b0;
         sck_d    = 1'b0;
         dio_oe_d = 4'hF;
         dio_o_d  = start_we ? 4'h3 : 4'hE;
      end
      if (end_frame) begin
         state_d     = S_DONE;
         cnt_d       = '0;
         sck_d       = 1'b0;
         ce_n_d      = 1'b1;
         dio_oe_d    = 4'h0;
         dio_o_d     = 4'h0;
         rsp_valid_d = 1'b1;
      end
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking '<=' for all state; the request/shift registers are reset too so an aborted frame leaves no stale data.
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sck_q       <= 1'b0;
         ce_n_q      <= 1'b1;
         dio_o_q     <= 4'h0;
         dio_oe_q    <= 4'h0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         wdata_q     <= '0;
         rdata_sh_q  <= '0;
`ifdef PSRAM_QPI_ENTER_EN
         qpi_entered_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sck_q       <= sck_d;
         ce_n_q      <= ce_n_d;
         dio_o_q     <= dio_o_d;
         dio_oe_q    <= dio_oe_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         wdata_q     <= wdata_d;
         rdata_sh_q  <= rdata_sh_d;
`ifdef PSRAM_QPI_ENTER_EN
         qpi_entered_q <= qpi_entered_d;
`endif
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign sck       = sck_q;
   assign ce_n      = ce_n_q;
   assign dio_o     = dio_o_q;
   assign dio_oe    = dio_oe_q;

endmodule

// File: tb/tb_psram_qpi_master.sv
// Directed bench for psram_qpi_master with a small behavioural PSRAM model.
module tb_psram_qpi_master;

   localparam int RD_WAIT = 7;
   localparam int CE_GAP  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid, req_ready, req_we;
   logic [23:0] req_addr;
   logic [1:0]  req_len;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        sck, ce_n;
   logic [3:0]  dio_o, dio_oe, dio_i;

   always #5 clk = ~clk;

   psram_qpi_master #(.RD_WAIT_CYCLES(RD_WAIT), .CE_GAP(CE_GAP)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .sck       (sck),
      .ce_n      (ce_n),
      .dio_o     (dio_o),
      .dio_oe    (dio_oe),
      .dio_i     (dio_i)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // PSRAM model and bus monitors.
   logic [7:0]  mem [0:255];
   logic [3:0]  nibs [0:31];
   logic [7:0]  cmd, spi_bits;
   logic [23:0] faddr;
   int rises = 0, oe_bad = 0, sck_idle_err = 0, ready_busy_err = 0, rsp_cnt = 0, enter_cnt = 0;

   // New frame: restart the rise counter.
   always @(negedge ce_n) begin
      rises  = 0;
      oe_bad = 0;
   end

   // Device side: sample on sck rise, drive read data after the rise.
   always @(posedge sck) begin
      int k;
      logic [7:0] b;
      if (ce_n) sck_idle_err++;
      rises++;
      if (rises <= 32) nibs[rises-1] = dio_o;
      if (dio_oe == 4'b0001) begin
         if (rises == 1) enter_cnt++;
         spi_bits = {spi_bits[6:0], dio_o[0]};
      end else if (rises <= 32) begin
         if (rises == 2) cmd = {nibs[0], nibs[1]};
         if (rises == 8) faddr = {nibs[2], nibs[3], nibs[4], nibs[5], nibs[6], nibs[7]};
         if (cmd == 8'h38 && rises > 8 && rises % 2 == 0)
            mem[(int'(faddr) + (rises - 9) / 2) % 256] = {nibs[rises-2], nibs[rises-1]};
         if (cmd == 8'hEB && rises > 8 && dio_oe != 4'h0) oe_bad++;
         if (cmd == 8'hEB && rises >= 8 + RD_WAIT && rises < 16 + RD_WAIT) begin
            k = rises - 8 - RD_WAIT;
            b = mem[(int'(faddr) + k / 2) % 256];
            dio_i = (k % 2 == 0) ? b[7:4] : b[3:0];
         end
      end
   end

   // Bus-side monitors sampled away from the active edge.
   always @(negedge clk) begin
      if (rsp_valid) rsp_cnt++;
      if (req_ready && !ce_n) ready_busy_err++;
   end

   function automatic logic [63:0] pack_nibs(input int n);
      logic [63:0] p = '0;
      for (int i = 0; i < n; i++) p = {p[59:0], nibs[i]};
      return p;
   endfunction

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_req(input logic we, input logic [23:0] addr, input logic [1:0] len,
                         input logic [31:0] wdata, input string tag);
      int c0;
      bit ok;
      c0 = rsp_cnt;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_len   = len;
      req_wdata = wdata;
      wait_ready(ok);
      check({tag, "_accept"}, 64'(ok), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(ok);
      check({tag, "_rsp"}, 64'(ok), 64'd1);
      check({tag, "_rsp_cycle"}, {req_ready, ce_n}, 2'b01);
      @(negedge clk);
      check({tag, "_gap"}, {sck, ce_n}, 2'b01);
      check({tag, "_rsp_count"}, rsp_cnt - c0, 1);
   endtask

   initial begin
      int c0, t_rsp, t_ce;
      bit ok;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      dio_i     = 4'h0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_len   = '0;
      req_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_outputs", {sck, ce_n, dio_o, dio_oe, req_ready, rsp_valid}, 12'h400);
      check("reset_rdata", rsp_rdata, 32'h0);
      reset = 1'b0;

      // Full-word write
      do_req(1'b1, 24'h000010, 2'd3, 32'hDDCCBBAA, "wr4");
      check("wr4_rises", rises, 16);
      check("wr4_nibbles", pack_nibs(16), 64'h38000010AABBCCDD);
`ifdef PSRAM_QPI_ENTER_EN
      check("qpi_enter_bits", spi_bits, 8'h35);
      check("qpi_enter_count", enter_cnt, 1);
`endif

      // Read back
      do_req(1'b0, 24'h000010, 2'd0, 32'h0, "rd1");
      check("rd1_rises", rises, 23);
      check("rd1_header", pack_nibs(8), 64'hEB000010);
      check("rd1_oe_released", oe_bad, 0);
      check("rd1_rdata", rsp_rdata, 32'hDDCCBBAA);

      // Single-byte write, rdata must hold
      do_req(1'b1, 24'h000013, 2'd0, 32'h00000055, "wr1");
      check("wr1_rises", rises, 10);
      check("wr1_nibbles", pack_nibs(10), 64'h3800001355);
      check("wr1_rdata_held", rsp_rdata, 32'hDDCCBBAA);

      do_req(1'b0, 24'h000010, 2'd0, 32'h0, "rd2");
      check("rd2_rdata", rsp_rdata, 32'h55CCBBAA);

      // Back-to-back with req_valid held
      c0 = rsp_cnt;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 24'h000020;
      req_len   = 2'd1;
      req_wdata = 32'h00001234;
      wait_ready(ok);
      check("b2b_accept1", 64'(ok), 64'd1);
      @(negedge clk);
      req_we = 1'b0;
      t_rsp  = -1;
      t_ce   = -1;
      for (int i = 0; i < 400; i++) begin
         if (t_rsp < 0 && rsp_valid) begin
            t_rsp = i;
            check("b2b_ready_at_rsp", req_ready, 1'b0);
         end else if (t_rsp >= 0 && !ce_n) begin
            t_ce = i;
            break;
         end
         @(negedge clk);
      end
      check("b2b_ce_gap", t_ce - t_rsp, CE_GAP);
      req_valid = 1'b0;
      wait_rsp(ok);
      check("b2b_rsp2", 64'(ok), 64'd1);
      check("b2b_rdata", rsp_rdata, 32'h00001234);
      check("b2b_rises", rises, 23);
      @(negedge clk);
      check("b2b_rsp_count", rsp_cnt - c0, 2);

      // Reset during ADDR nibble 3
      c0 = rsp_cnt;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 24'h000040;
      req_len   = 2'd3;
      req_wdata = 32'h11223344;
      wait_ready(ok);
      check("abort_accept", 64'(ok), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (rises == 5 && sck) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("abort_reach_addr3", 64'(ok), 64'd1);
      #1 reset = 1'b1;
      #1;
      check("abort_outputs", {ce_n, sck, dio_oe}, 6'b100000);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_no_rsp", rsp_cnt - c0, 0);

      do_req(1'b0, 24'h000010, 2'd0, 32'h0, "rd3");
      check("rd3_rises", rises, 23);
      check("rd3_rdata", rsp_rdata, 32'h55CCBBAA);
`ifdef PSRAM_QPI_ENTER_EN
      check("qpi_enter_after_reset", enter_cnt, 2);
`endif

      check("sck_only_in_frame", sck_idle_err, 0);
      check("ready_low_in_frame", ready_busy_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
